// File: rtl/rdn_iru_bridge.sv
// RDN -> IRU bridge: captures a 20x20 frame and one-hot angle, then streams it row by row.
// Optional build macro RDN_IRU_ANGLE_CHECK_EN adds a one-hot check on the captured angle.
module rdn_iru_bridge #(
    parameter int unsigned NUM_C_NEURONS  = 36,
    parameter int unsigned ANGLE_STEP_DEG = 10,
    parameter int unsigned IMG_DIM        = 20
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rdn_valid,
    input  logic [NUM_C_NEURONS-1:0]     rdn_angle,
    input  logic [4:0][79:0][7:0]        rdn_q,
    output logic                         rdn_ready,
    output logic                         row_valid,
    input  logic                         row_ready,
    output logic [IMG_DIM-1:0][7:0]      row_data,
    output logic [4:0]                   row_idx,
    output logic                         row_last,
    output logic [5:0]                   angle_idx,
    output logic [8:0]                   angle_deg,
    output logic                         angle_err,
    output logic [15:0]                  frame_cnt
);

    localparam logic [4:0] LastRow = 5'(IMG_DIM - 1);

    typedef enum logic {StIdle, StStream} state_e;

    state_e                              state_q;
    logic                                rdn_ready_q;
    logic                                row_valid_q;
    logic [4:0]                          row_idx_q;
    logic [5:0]                          angle_idx_q;
    logic [8:0]                          angle_deg_q;
    logic                                angle_err_q;
    logic [15:0]                         frame_cnt_q;
    logic [IMG_DIM-1:0][IMG_DIM-1:0][7:0] frame_q;
    logic [IMG_DIM-1:0][IMG_DIM-1:0][7:0] frame_in;

    logic [5:0] enc_idx;
    logic [5:0] cap_idx;
    logic [8:0] cap_deg;
    logic       cap_err;

    // Reorder the flat 5x80 byte image into rows of IMG_DIM pixels.
    for (genvar r = 0; r < IMG_DIM; r++) begin : g_row
        for (genvar k = 0; k < IMG_DIM; k++) begin : g_pix
            assign frame_in[r][k] = rdn_q[(r*IMG_DIM+k)/80][(r*IMG_DIM+k)%80];
        end
    end

    // Descending scan so the lowest set bit wins; all-zero leaves index 0.
    always_comb begin
        enc_idx = '0;
        for (int i = NUM_C_NEURONS - 1; i >= 0; i--) begin
            if (rdn_angle[i]) enc_idx = 6'(i);
        end
    end

`ifdef RDN_IRU_ANGLE_CHECK_EN
    assign cap_err = ($countones(rdn_angle) != 1);
    assign cap_idx = cap_err ? 6'd0 : enc_idx;
`else
    assign cap_err = 1'b0;
    assign cap_idx = enc_idx;
`endif

    assign cap_deg = 9'(cap_idx) * 9'(ANGLE_STEP_DEG);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rdn_ready_q <= 1'b1;
            row_valid_q <= 1'b0;
            row_idx_q   <= '0;
            angle_idx_q <= '0;
            angle_deg_q <= '0;
            angle_err_q <= 1'b0;
            frame_cnt_q <= '0;
            frame_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rdn_valid) begin
                        frame_q     <= frame_in;
                        angle_idx_q <= cap_idx;
                        angle_deg_q <= cap_deg;
                        angle_err_q <= cap_err;
                        row_idx_q   <= '0;
                        rdn_ready_q <= 1'b0;
                        row_valid_q <= 1'b1;
                        state_q     <= StStream;
                    end
                end
                StStream: begin
                    if (row_ready) begin
                        if (row_idx_q == LastRow) begin
                            row_idx_q   <= '0;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            rdn_ready_q <= 1'b1;
                            row_valid_q <= 1'b0;
                            state_q     <= StIdle;
                        end else begin
                            row_idx_q <= row_idx_q + 5'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rdn_ready = rdn_ready_q;
    assign row_valid = row_valid_q;
    assign row_idx   = row_idx_q;
    assign row_data  = frame_q[row_idx_q];
    assign row_last  = row_valid_q && (row_idx_q == LastRow);
    assign angle_idx = angle_idx_q;
    assign angle_deg = angle_deg_q;
    assign angle_err = angle_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_rdn_iru_bridge.sv
// Randomized bench for rdn_iru_bridge against a frame/angle reference model.
// Honours RDN_IRU_ANGLE_CHECK_EN the same way as the design.
module tb_rdn_iru_bridge;

    localparam int NC = 36;
    localparam int D  = 20;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  rdn_valid;
    logic [NC-1:0]         rdn_angle;
    logic [4:0][79:0][7:0] rdn_q;
    logic                  rdn_ready;
    logic                  row_valid;
    logic                  row_ready;
    logic [D-1:0][7:0]     row_data;
    logic [4:0]            row_idx;
    logic                  row_last;
    logic [5:0]            angle_idx;
    logic [8:0]            angle_deg;
    logic                  angle_err;
    logic [15:0]           frame_cnt;

    rdn_iru_bridge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rdn_valid (rdn_valid),
        .rdn_angle (rdn_angle),
        .rdn_q     (rdn_q),
        .rdn_ready (rdn_ready),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .row_idx   (row_idx),
        .row_last  (row_last),
        .angle_idx (angle_idx),
        .angle_deg (angle_deg),
        .angle_err (angle_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [7:0]    pix [D*D];
    logic [NC-1:0] cur_angle;
    int            exp_cnt = 0;

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference angle rules: lowest set bit, optional one-hot check.
    task automatic model_angle(input logic [NC-1:0] a, output int idx, output int deg,
                               output int err);
        int ones = 0;
        int low  = -1;
        for (int i = 0; i < NC; i++) begin
            if (a[i]) begin
                ones++;
                if (low < 0) low = i;
            end
        end
        if (low < 0) low = 0;
        err = 0;
`ifdef RDN_IRU_ANGLE_CHECK_EN
        if (ones != 1) begin
            err = 1;
            low = 0;
        end
`endif
        idx = low;
        deg = low * 10;
    endtask

    function automatic logic [159:0] exp_row(input int r);
        logic [D-1:0][7:0] v;
        for (int k = 0; k < D; k++) v[k] = pix[r*D+k];
        return v;
    endfunction

    function automatic logic [NC-1:0] rand_angle();
        int kind = $urandom_range(0, 5);
        if (kind == 0) return '0;
        if (kind == 1) return {4'($urandom), 32'($urandom)};
        return 36'(1) << $urandom_range(0, NC-1);
    endfunction

    task automatic fill_pix(input int directed);
        for (int p = 0; p < D*D; p++) pix[p] = directed ? 8'(p) : 8'($urandom);
    endtask

    task automatic scramble_inputs();
        for (int p = 0; p < D*D; p++) rdn_q[p/80][p%80] = 8'($urandom);
        rdn_angle = rand_angle();
    endtask

    // Called at a negedge; waits (bounded) for rdn_ready and presents one frame.
    task automatic capture(input logic [NC-1:0] a);
        int w = 0;
        while (!rdn_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!rdn_ready) check_eq("accept_timeout", rdn_ready, 1);
        for (int p = 0; p < D*D; p++) rdn_q[p/80][p%80] = pix[p];
        cur_angle = a;
        rdn_angle = a;
        rdn_valid = 1'b1;
        @(negedge clk);
        rdn_valid = 1'b0;
        scramble_inputs();
    endtask

    // mode: 0 always ready, 1 pattern 1,0,0,1, 2 random. rst_at < 0 disables the reset.
    task automatic stream(input int mode, input int busy, input int rst_at);
        int r = 0;
        int cyc = 0;
        int ei, ed, ee;
        logic rr;
        model_angle(cur_angle, ei, ed, ee);
        while (r < D && cyc < 400) begin
            if (r == rst_at) begin
                rst_n     = 1'b0;
                row_ready = 1'b1;
                @(negedge clk);
                rst_n     = 1'b1;
                row_ready = 1'b0;
                exp_cnt   = 0;
                check_eq("rst_row_valid", row_valid, 0);
                check_eq("rst_row_idx", row_idx, 0);
                check_eq("rst_rdn_ready", rdn_ready, 1);
                check_eq("rst_row_last", row_last, 0);
                check_eq("rst_frame_cnt", frame_cnt, 0);
                check_eq("rst_angle_idx", angle_idx, 0);
                check_eq("rst_angle_deg", angle_deg, 0);
                check_eq("rst_buffer", row_data, 0);
                return;
            end
            check_eq("row_valid", row_valid, 1);
            check_eq("row_idx", row_idx, r);
            check_eq("row_data", row_data, exp_row(r));
            check_eq("row_last", row_last, (r == D-1));
            check_eq("rdn_ready_busy", rdn_ready, 0);
            check_eq("angle_idx", angle_idx, ei);
            check_eq("angle_deg", angle_deg, ed);
            check_eq("angle_err", angle_err, ee);
            if (mode == 0)      rr = 1'b1;
            else if (mode == 1) rr = (cyc % 4 == 0) || (cyc % 4 == 3);
            else                rr = 1'($urandom);
            row_ready = rr;
            rdn_valid = (busy != 0) && (r == 5);
            if (rdn_valid) scramble_inputs();
            @(negedge clk);
            if (rr) r++;
            cyc++;
        end
        row_ready = 1'b0;
        rdn_valid = 1'b0;
        check_eq("beats", r, D);
        exp_cnt++;
        check_eq("frame_cnt", frame_cnt, exp_cnt);
        check_eq("end_rdn_ready", rdn_ready, 1);
        check_eq("end_row_valid", row_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        rdn_valid = 1'b0;
        row_ready = 1'b0;
        rdn_angle = '0;
        rdn_q     = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset_rdn_ready", rdn_ready, 1);
        check_eq("reset_row_valid", row_valid, 0);
        check_eq("reset_frame_cnt", frame_cnt, 0);
        check_eq("reset_angle_idx", angle_idx, 0);
        check_eq("reset_angle_deg", angle_deg, 0);
        check_eq("reset_angle_err", angle_err, 0);
        check_eq("reset_row_idx", row_idx, 0);

        fill_pix(1);
        capture(36'(1) << 9);
        stream(0, 0, -1);

        fill_pix(0);
        capture(rand_angle());
        stream(1, 0, -1);

        fill_pix(0);
        capture(36'(1) << $urandom_range(0, NC-1));
        stream(2, 1, -1);

        fill_pix(0);
        capture(36'h0_0000_0028);
        stream(0, 0, -1);

        fill_pix(0);
        capture('0);
        stream(2, 0, -1);

        fill_pix(0);
        capture(36'(1) << 35);
        stream(0, 0, 7);

        fill_pix(1);
        capture(36'(1) << 1);
        stream(0, 0, -1);

        for (int f = 0; f < 8; f++) begin
            fill_pix(0);
            capture(rand_angle());
            stream(int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
